// File: rtl/isdu_if.sv
// isdu_if: control bus between the LC-3 sequencer and its datapath/SRAM
//   inputs to the sequencer: Run, Continue, Opcode, IR_5, IR_11, BEN, Mem_Ready
//   outputs: register loads, bus gates, mux selects, ALUK, SRAM strobes, Busy
interface isdu_if;
  logic       Run, Continue, IR_5, IR_11, BEN, Mem_Ready;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic       Mem_OE, Mem_WE, Busy;
  modport master (
    output Run, Continue, Opcode, IR_5, IR_11, BEN, Mem_Ready,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
    input  Mem_OE, Mem_WE, Busy
  );
  modport slave (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN, Mem_Ready,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
    output Mem_OE, Mem_WE, Busy
  );
endinterface

// File: rtl/isdu_param.sv
// isdu_param: parametrised LC-3 Moore sequencer/decoder with counted or ready-handshake memory access
//   Clk, Reset (sync, active-high) plain ports; everything else on bus (isdu_if.slave)
module isdu_param #(
  parameter int MEM_WAIT   = 3,
  parameter int READY_MODE = 0,
  parameter int CNT_W      = 4
) (
  input logic   Clk,
  input logic   Reset,
  isdu_if.slave bus
);
  typedef enum logic [4:0] {
    HALTED, FETCH, RD, WR, IR, DECODE, ADD, AND, NOT, LEA, ADR9, ADR6,
    PTR, SPTR, WB, SDATA, BRT, JMP, SAVE, JSR1, JSRR1, P1, P2
  } state_t;
  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic mem_oe, mem_we, busy;
  } ctl_t;
  state_t st, nxt, ret, nxt_ret;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic done;
  ctl_t c, n;
  assign done = READY_MODE != 0 ? bus.Mem_Ready : cnt == CNT_W'(MEM_WAIT - 1);
  // The wait counter only runs inside RD/WR, so every access entry starts from zero.
  always_comb begin
    nxt = st;
    nxt_ret = ret;
    nxt_cnt = '0;
    case (st)
      HALTED: nxt = bus.Run ? FETCH : HALTED;
      FETCH: begin
        nxt = RD;
        nxt_ret = IR;
      end
      RD, WR: begin
        nxt = done ? ret : st;
        nxt_cnt = done ? '0 : cnt + 1'b1;
      end
      IR: nxt = DECODE;
      DECODE:
        case (bus.Opcode)
          4'b0001: nxt = ADD;
          4'b0101: nxt = AND;
          4'b1001: nxt = NOT;
          4'b1110: nxt = LEA;
          4'b0010, 4'b0011, 4'b1010, 4'b1011: nxt = ADR9;
          4'b0110, 4'b0111: nxt = ADR6;
          4'b0000: nxt = bus.BEN ? BRT : FETCH;
          4'b1100: nxt = JMP;
          4'b0100: nxt = SAVE;
          4'b1101: nxt = P1;
          default: nxt = FETCH;
        endcase
      // Opcode[0] marks a store and Opcode[3] an indirect access; plain stores skip memory here.
      ADR9, ADR6: begin
        nxt = bus.Opcode[0] && !bus.Opcode[3] ? SDATA : RD;
        nxt_ret = bus.Opcode[0] ? SPTR : bus.Opcode[3] ? PTR : WB;
      end
      PTR: begin
        nxt = RD;
        nxt_ret = WB;
      end
      SPTR: nxt = SDATA;
      SDATA: begin
        nxt = WR;
        nxt_ret = FETCH;
      end
      SAVE: nxt = bus.IR_11 ? JSR1 : JSRR1;
      P1: nxt = bus.Continue ? P2 : P1;
      P2: nxt = bus.Continue ? P2 : FETCH;
      default: nxt = FETCH;
    endcase
  end
  // Controls are decoded from the upcoming state and registered, so they are a pure function of state.
  always_comb begin
    n = '0;
    n.busy = !(nxt inside {HALTED, P1, P2});
    case (nxt)
      FETCH: begin
        n.gate_pc = 1'b1;
        n.ld_mar = 1'b1;
        n.ld_pc = 1'b1;
      end
      RD: begin
        n.mem_oe = 1'b1;
        n.ld_mdr = READY_MODE == 0 && nxt_cnt == CNT_W'(MEM_WAIT - 1);
      end
      WR: n.mem_we = 1'b1;
      IR: begin
        n.gate_mdr = 1'b1;
        n.ld_ir = 1'b1;
      end
      DECODE: n.ld_ben = 1'b1;
      ADD, AND: begin
        n.gate_alu = 1'b1;
        n.ld_reg = 1'b1;
        n.ld_cc = 1'b1;
        n.sr2mux = bus.IR_5;
        n.aluk = {1'b0, nxt == AND};
      end
      NOT: begin
        n.aluk = 2'b10;
        n.gate_alu = 1'b1;
        n.ld_reg = 1'b1;
        n.ld_cc = 1'b1;
      end
      LEA: begin
        n.addr2mux = 2'b10;
        n.gate_marmux = 1'b1;
        n.ld_reg = 1'b1;
        n.ld_cc = 1'b1;
      end
      ADR9: begin
        n.addr2mux = 2'b10;
        n.gate_marmux = 1'b1;
        n.ld_mar = 1'b1;
      end
      ADR6: begin
        n.addr1mux = 1'b1;
        n.addr2mux = 2'b01;
        n.gate_marmux = 1'b1;
        n.ld_mar = 1'b1;
      end
      PTR, SPTR: begin
        n.gate_mdr = 1'b1;
        n.ld_mar = 1'b1;
      end
      WB: begin
        n.gate_mdr = 1'b1;
        n.ld_reg = 1'b1;
        n.ld_cc = 1'b1;
      end
      SDATA: begin
        n.sr1mux = 1'b1;
        n.aluk = 2'b11;
        n.gate_alu = 1'b1;
        n.ld_mdr = 1'b1;
      end
      BRT: begin
        n.addr2mux = 2'b10;
        n.pcmux = 2'b10;
        n.ld_pc = 1'b1;
      end
      JMP: begin
        n.aluk = 2'b11;
        n.gate_alu = 1'b1;
        n.pcmux = 2'b01;
        n.ld_pc = 1'b1;
      end
      SAVE: begin
        n.gate_pc = 1'b1;
        n.drmux = 1'b1;
        n.ld_reg = 1'b1;
      end
      JSR1: begin
        n.addr2mux = 2'b11;
        n.pcmux = 2'b10;
        n.ld_pc = 1'b1;
      end
      JSRR1: begin
        n.addr1mux = 1'b1;
        n.pcmux = 2'b10;
        n.ld_pc = 1'b1;
      end
      P1, P2: n.ld_led = 1'b1;
      default: ;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st <= HALTED;
      ret <= HALTED;
      cnt <= '0;
      c <= '0;
    end else begin
      st <= nxt;
      ret <= nxt_ret;
      cnt <= nxt_cnt;
      c <= n;
    end
  end
  assign bus.LD_MAR = c.ld_mar;
  // In ready mode MDR must capture on the very cycle the memory reports completion.
  assign bus.LD_MDR = c.ld_mdr | (READY_MODE != 0 && st == RD && bus.Mem_Ready);
  assign bus.LD_IR = c.ld_ir;
  assign bus.LD_BEN = c.ld_ben;
  assign bus.LD_CC = c.ld_cc;
  assign bus.LD_REG = c.ld_reg;
  assign bus.LD_PC = c.ld_pc;
  assign bus.LD_LED = c.ld_led;
  assign bus.GatePC = c.gate_pc;
  assign bus.GateMDR = c.gate_mdr;
  assign bus.GateALU = c.gate_alu;
  assign bus.GateMARMUX = c.gate_marmux;
  assign bus.PCMUX = c.pcmux;
  assign bus.DRMUX = c.drmux;
  assign bus.SR1MUX = c.sr1mux;
  assign bus.SR2MUX = c.sr2mux;
  assign bus.ADDR1MUX = c.addr1mux;
  assign bus.ADDR2MUX = c.addr2mux;
  assign bus.ALUK = c.aluk;
  assign bus.Mem_OE = c.mem_oe;
  assign bus.Mem_WE = c.mem_we;
  assign bus.Busy = c.busy;
endmodule

// File: tb/tb_isdu_param.sv
// tb_isdu_param: randomized scoreboard bench for the LC-3 sequencer in counter mode and ready mode
module tb_isdu_param;
  localparam int W = 3;
  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic mem_oe, mem_we, busy;
  } ctl_t;
  typedef struct packed {
    logic rst, run, cont, mr, ir5, ir11, ben;
    logic [3:0] op;
    ctl_t e;
  } rec_t;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  int total = 0;
  int bad = 0;
  ctl_t eq[2][$];
  ctl_t act[2];
  ctl_t x;
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : gd
      localparam int RM = g;
      logic rs;
      bit done;
      bit halted;
      logic [3:0] cop;
      bit cir5, cir11, cben;
      rec_t sq[$];
      rec_t r;
      isdu_if b();
      isdu_param #(.MEM_WAIT(W), .READY_MODE(RM), .CNT_W(4)) u (.Clk(Clk), .Reset(rs), .bus(b.slave));
      assign act[g] = {b.LD_MAR, b.LD_MDR, b.LD_IR, b.LD_BEN, b.LD_CC, b.LD_REG, b.LD_PC, b.LD_LED,
                       b.GatePC, b.GateMDR, b.GateALU, b.GateMARMUX, b.PCMUX, b.DRMUX, b.SR1MUX,
                       b.SR2MUX, b.ADDR1MUX, b.ADDR2MUX, b.ALUK, b.Mem_OE, b.Mem_WE, b.Busy};
      function automatic ctl_t bz();
        ctl_t e = '0;
        e.busy = 1'b1;
        return e;
      endfunction
      task automatic put(ctl_t e, bit mr, bit ct, bit rn, bit rst);
        rec_t q;
        q.rst = rst; q.run = rn; q.cont = ct; q.mr = mr;
        q.ir5 = cir5; q.ir11 = cir11; q.ben = cben; q.op = cop; q.e = e;
        sq.push_back(q);
      endtask
      task automatic cy(ctl_t e);
        put(e, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      endtask
      task automatic acc(bit wr, int lat);
        int n = RM != 0 ? (lat < 0 ? int'($urandom_range(3, 0)) : lat) + 1 : W;
        for (int i = 0; i < n; i++) begin
          ctl_t e = bz();
          e.mem_oe = !wr;
          e.mem_we = wr;
          e.ld_mdr = !wr && i == n - 1;
          put(e, RM != 0 ? i == n - 1 : 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
      endtask
      task automatic fetch(int lat);
        ctl_t e;
        if (halted) begin
          repeat ($urandom_range(1, 0)) put('0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
          put('0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
          halted = 0;
        end
        e = bz(); e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1; cy(e);
        acc(1'b0, lat);
        e = bz(); e.gate_mdr = 1; e.ld_ir = 1; cy(e);
        e = bz(); e.ld_ben = 1; cy(e);
      endtask
      task automatic instr(logic [3:0] op, bit ir5, bit ir11, bit ben, int flat, int lat);
        ctl_t e = bz();
        cop = op; cir5 = ir5; cir11 = ir11; cben = ben;
        fetch(flat);
        case (op)
          4'b0001, 4'b0101: begin
            e.gate_alu = 1; e.ld_reg = 1; e.ld_cc = 1; e.sr2mux = ir5;
            e.aluk = op == 4'b0101 ? 2'b01 : 2'b00; cy(e);
          end
          4'b1001: begin e.aluk = 2'b10; e.gate_alu = 1; e.ld_reg = 1; e.ld_cc = 1; cy(e); end
          4'b1110: begin e.addr2mux = 2'b10; e.gate_marmux = 1; e.ld_reg = 1; e.ld_cc = 1; cy(e); end
          4'b0010, 4'b1010, 4'b0110, 4'b0011, 4'b1011, 4'b0111: begin
            e.gate_marmux = 1; e.ld_mar = 1;
            if (op[2:0] == 3'b110 || op[2:0] == 3'b111) begin e.addr1mux = 1; e.addr2mux = 2'b01; end
            else e.addr2mux = 2'b10;
            cy(e);
            if (op == 4'b0010 || op == 4'b0110 || op == 4'b1010) begin
              acc(1'b0, lat);
              if (op == 4'b1010) begin
                e = bz(); e.gate_mdr = 1; e.ld_mar = 1; cy(e);
                acc(1'b0, lat);
              end
              e = bz(); e.gate_mdr = 1; e.ld_reg = 1; e.ld_cc = 1; cy(e);
            end else begin
              if (op == 4'b1011) begin
                acc(1'b0, lat);
                e = bz(); e.gate_mdr = 1; e.ld_mar = 1; cy(e);
              end
              e = bz(); e.sr1mux = 1; e.aluk = 2'b11; e.gate_alu = 1; e.ld_mdr = 1; cy(e);
              acc(1'b1, lat);
            end
          end
          4'b0000: if (ben) begin e.addr2mux = 2'b10; e.pcmux = 2'b10; e.ld_pc = 1; cy(e); end
          4'b1100: begin e.aluk = 2'b11; e.gate_alu = 1; e.pcmux = 2'b01; e.ld_pc = 1; cy(e); end
          4'b0100: begin
            e.gate_pc = 1; e.drmux = 1; e.ld_reg = 1; cy(e);
            e = bz(); e.pcmux = 2'b10; e.ld_pc = 1;
            if (ir11) e.addr2mux = 2'b11; else e.addr1mux = 1;
            cy(e);
          end
          4'b1101: begin
            e = '0; e.ld_led = 1;
            repeat ($urandom_range(2, 0)) put(e, 1'($urandom), 1'b0, 1'($urandom), 1'b0);
            put(e, 1'($urandom), 1'b1, 1'($urandom), 1'b0);
            repeat ($urandom_range(2, 0)) put(e, 1'($urandom), 1'b1, 1'($urandom), 1'b0);
            put(e, 1'($urandom), 1'b0, 1'($urandom), 1'b0);
          end
          default: ;
        endcase
      endtask
      task automatic abort();
        ctl_t e = bz();
        e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1; cy(e);
        e = bz(); e.mem_oe = 1;
        put(e, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
        put(e, 1'b0, 1'($urandom), 1'($urandom), 1'b1);
        halted = 1;
      endtask
      initial begin
        halted = 1; cop = '0; cir5 = 0; cir11 = 0; cben = 0; done = 0;
        rs = 1'b1;
        b.Run = 0; b.Continue = 0; b.Opcode = '0; b.IR_5 = 0; b.IR_11 = 0; b.BEN = 0; b.Mem_Ready = 0;
        put('0, 1'b0, 1'b0, 1'b0, 1'b0);
        instr(4'b0001, 0, 0, 0, -1, -1);
        instr(4'b1010, 1, 0, 0, -1, -1);
        instr(4'b0111, 0, 0, 0, 0, 5);
        instr(4'b0000, 0, 1, 0, -1, -1);
        instr(4'b0000, 0, 1, 1, -1, -1);
        instr(4'b0100, 0, 0, 0, -1, -1);
        instr(4'b0100, 0, 1, 0, -1, -1);
        instr(4'b1101, 1, 0, 0, -1, -1);
        abort();
        instr(4'b0001, 1, 0, 0, -1, -1);
        for (int k = 0; k < 16; k++) instr(4'(k), 1'($urandom), 1'($urandom), 1'($urandom), -1, -1);
        for (int k = 0; k < 150; k++) begin
          instr(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1, -1);
          if ($urandom_range(19, 0) == 0) abort();
        end
        repeat (2) @(posedge Clk);
        while (sq.size() != 0) begin
          #1;
          r = sq.pop_front();
          rs = r.rst; b.Run = r.run; b.Continue = r.cont; b.Mem_Ready = r.mr;
          b.IR_5 = r.ir5; b.IR_11 = r.ir11; b.BEN = r.ben; b.Opcode = r.op;
          eq[g].push_back(r.e);
          @(posedge Clk);
        end
        done = 1;
      end
    end
  endgenerate
  always @(negedge Clk)
    for (int i = 0; i < 2; i++)
      if (eq[i].size() != 0) begin
        x = eq[i].pop_front();
        total++;
        if (act[i] !== x) begin
          bad++;
          $display("FAIL ctl dut%0d t=%0t got=%h exp=%h", i, $time, act[i], x);
        end
      end
  initial begin
    wait (gd[0].done && gd[1].done);
    repeat (2) @(negedge Clk);
    if (bad != 0) $display("FAIL mismatches got=%0d exp=0", bad);
    if (total < 1000) $display("FAIL coverage got=%0d exp>=1000", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end
endmodule
